// File: rtl/dma_pkg.sv
// Shared types and helpers for the burst DMA engine.
// Holds the FSM state type, AXI constants and burst sizing.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_DONE
  } dma_state_e;

  localparam logic [1:0] AXI_BURST_INC = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  // Beats for the next burst: bounded by words left, the
  // burst cap and the 4 KB page of both source and dest.
  function automatic logic [8:0] calc_beats(
    input logic [31:0] rem,
    input logic [11:0] src,
    input logic [11:0] dst,
    input logic [8:0]  max_b,
    input logic [3:0]  shift
  );
    logic [8:0]  n;
    logic [12:0] s;
    logic [12:0] d;
    if (rem > {23'd0, max_b}) n = max_b;
    else n = rem[8:0];
    s = (13'd4096 - {1'b0, src}) >> shift;
    d = (13'd4096 - {1'b0, dst}) >> shift;
    if (s < {4'd0, n}) n = s[8:0];
    if (d < {4'd0, n}) n = d[8:0];
    return n;
  endfunction

endpackage

// File: rtl/dma_fifo.sv
// Read-data staging FIFO, first-word fall-through.
// Ports: push_i/data_i in, pop_i in, head_o/empty_o/full_o out.
module dma_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [AW:0]      cnt_q;

  assign head_o  = mem_q[rp_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        assert (!full_o);
        wp_q <= (wp_q == AW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
      end
      if (pop_i) begin
        rp_q <= (rp_q == AW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
      end
      if (push_i && !pop_i) cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/dma_burst_engine.sv
// Single-channel AXI master DMA copying DMALEN words in
// 4 KB-safe INCR bursts; DMAEN/DMASRC/DMADST/DMALEN in,
// DMA_interrupt/DMA_error out, plus one AXI master port.
module dma_burst_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MAX_BURST = 16,
  parameter int RD_ID     = 0,
  parameter int WR_ID     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                DMAEN,
  input  logic [ADDR_W-1:0]   DMASRC,
  input  logic [ADDR_W-1:0]   DMADST,
  input  logic [31:0]         DMALEN,
  output logic                DMA_interrupt,
  output logic                DMA_error,
  output logic [ID_W-1:0]     M_AWID,
  output logic [ADDR_W-1:0]   M_AWAddr,
  output logic [7:0]          M_AWLen,
  output logic [2:0]          M_AWSize,
  output logic [1:0]          M_AWBurst,
  output logic                M_AWValid,
  input  logic                M_AWReady,
  output logic [DATA_W-1:0]   M_WData,
  output logic [DATA_W/8-1:0] M_WStrb,
  output logic                M_WLast,
  output logic                M_WValid,
  input  logic                M_WReady,
  input  logic [ID_W-1:0]     M_BID,
  input  logic [1:0]          M_BResp,
  input  logic                M_BValid,
  output logic                M_BReady,
  output logic [ID_W-1:0]     M_ARID,
  output logic [ADDR_W-1:0]   M_ARAddr,
  output logic [7:0]          M_ARLen,
  output logic [2:0]          M_ARSize,
  output logic [1:0]          M_ARBurst,
  output logic                M_ARValid,
  input  logic                M_ARReady,
  input  logic [ID_W-1:0]     M_RID,
  input  logic [DATA_W-1:0]   M_RData,
  input  logic [1:0]          M_RResp,
  input  logic                M_RLast,
  input  logic                M_RValid,
  output logic                M_RReady
);

  localparam int         SHIFT = $clog2(DATA_W/8);
  localparam logic [8:0] MAXB  = 9'(MAX_BURST);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] step;
  logic [31:0]       rem_q, rem_d;
  logic [8:0]        beats_q, beats_d;
  logic [8:0]        rcnt_q, rcnt_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic [8:0]        last_idx;
  logic              rerr_q, rerr_d;
  logic              err_q, err_d;
  logic              arvalid_q, awvalid_q, irq_q;
  logic              r_hs, w_hs;
  logic              fifo_rst, fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              unused_ok;

  // RLast, IDs and the low response bit carry no decision.
  assign unused_ok = ^{M_BID, M_RID, M_RLast, M_RResp[0],
                       M_BResp[0], fifo_full, RESP_OKAY};

  assign last_idx = beats_q - 9'd1;
  assign step     = ADDR_W'(beats_q) << SHIFT;

  assign M_ARID    = ID_W'(RD_ID);
  assign M_ARAddr  = src_q;
  assign M_ARLen   = last_idx[7:0];
  assign M_ARSize  = 3'(SHIFT);
  assign M_ARBurst = AXI_BURST_INC;
  assign M_ARValid = arvalid_q;
  assign M_RReady  = (state_q == S_RDATA);

  assign M_AWID    = ID_W'(WR_ID);
  assign M_AWAddr  = dst_q;
  assign M_AWLen   = last_idx[7:0];
  assign M_AWSize  = 3'(SHIFT);
  assign M_AWBurst = AXI_BURST_INC;
  assign M_AWValid = awvalid_q;

  assign M_WValid = (state_q == S_WDATA) && !fifo_empty;
  assign M_WData  = fifo_head;
  assign M_WStrb  = '1;
  assign M_WLast  = M_WValid && (wcnt_q == last_idx);
  assign M_BReady = (state_q == S_WRESP);

  assign DMA_interrupt = irq_q;
  assign DMA_error     = err_q;

  assign r_hs = M_RReady && M_RValid;
  assign w_hs = M_WValid && M_WReady;

  // Idle flushes data left behind by an aborted read burst.
  assign fifo_rst = rst || (state_q == S_IDLE);

  dma_fifo #(
    .DEPTH (MAX_BURST),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (fifo_rst),
    .push_i  (r_hs),
    .data_i  (M_RData),
    .pop_i   (w_hs),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    rcnt_d  = rcnt_q;
    wcnt_d  = wcnt_q;
    rerr_d  = rerr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (DMAEN) begin
          src_d   = DMASRC;
          dst_d   = DMADST;
          rem_d   = DMALEN;
          err_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          beats_d = calc_beats(rem_q, src_q[11:0], dst_q[11:0],
                               MAXB, 4'(SHIFT));
          rcnt_d  = '0;
          wcnt_d  = '0;
          rerr_d  = 1'b0;
          state_d = S_RADDR;
        end
      end
      S_RADDR: begin
        if (M_ARReady) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (r_hs) begin
          rcnt_d = rcnt_q + 9'd1;
          if (M_RResp[1]) rerr_d = 1'b1;
          // Beat count, not RLast, ends the burst.
          if (rcnt_q == last_idx) begin
            if (rerr_q || M_RResp[1]) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_WADDR;
            end
          end
        end
      end
      S_WADDR: begin
        if (M_AWReady) state_d = S_WDATA;
      end
      S_WDATA: begin
        if (w_hs) begin
          wcnt_d = wcnt_q + 9'd1;
          if (wcnt_q == last_idx) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (M_BValid) begin
          if (M_BResp[1]) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            src_d   = src_q + step;
            dst_d   = dst_q + step;
            rem_d   = rem_q - {23'd0, beats_q};
            state_d = S_CALC;
          end
        end
      end
      S_DONE: begin
        if (!DMAEN) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      rerr_q    <= 1'b0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      beats_q   <= beats_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      rerr_q    <= rerr_d;
      err_q     <= err_d;
      arvalid_q <= (state_d == S_RADDR);
      awvalid_q <= (state_d == S_WADDR);
      irq_q     <= (state_d == S_DONE);
    end
  end

endmodule
